// File: rtl/reg_file_pkg.sv
// Shared constants for the configurable register file.
//   DEF_*      default parameter values for reg_file_cfg
//   slice_lo() lowest bit of register k inside the flat REG_OUT bus
package reg_file_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_EXPORT = 4;

  // Register k occupies REG_OUT[slice_lo(k, w) +: w].
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_cfg.sv
// Configurable register file with a software port and a hardware status port.
//
// Ports
//   CLK          block clock, rising edge
//   RST          asynchronous active-low reset
//   WrData       software write data
//   Address      software read/write address
//   WrEn, RdEn   software strobes
//   HwWrEn       hardware write strobe (only reaches read-only registers)
//   HwAddress    hardware write address
//   HwWrData     hardware write data
//   RdData       registered read data, holds between reads
//   RdData_Valid one-cycle pulse: RdData carries a fresh read response
//   Err          one-cycle pulse: the previous cycle's software access was rejected
//   REG_OUT      registers 0..NUM_EXPORT-1, register k on [k*WIDTH +: WIDTH]
//
// Strobe protocol: WrEn/RdEn/HwWrEn are single-cycle requests sampled on every
// rising CLK edge; there is no back-pressure. Each accepted strobe produces its
// response (RdData_Valid and/or Err) on the cycle directly after that edge, and
// a write takes priority over a read issued in the same cycle.
module reg_file_cfg
  import reg_file_pkg::*;
#(
  parameter int                 WIDTH      = DEF_WIDTH,
  parameter int                 DEPTH      = DEF_DEPTH,
  parameter int                 ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DEPTH-1:0]   RO_MASK    = '0,
  parameter int                 NUM_EXPORT = DEF_NUM_EXPORT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            WrData,
  input  logic [ADDR_WIDTH-1:0]       Address,
  input  logic                        WrEn,
  input  logic                        RdEn,
  input  logic                        HwWrEn,
  input  logic [ADDR_WIDTH-1:0]       HwAddress,
  input  logic [WIDTH-1:0]            HwWrData,
  output logic [WIDTH-1:0]            RdData,
  output logic                        RdData_Valid,
  output logic                        Err,
  output logic [NUM_EXPORT*WIDTH-1:0] REG_OUT
);

  logic [WIDTH-1:0] regs [DEPTH];

  // One-hot address decode. An address beyond DEPTH-1 matches no entry, so
  // the range check and the read mux both fall out of the same loop.
  logic [DEPTH-1:0] sw_sel;
  logic [DEPTH-1:0] hw_sel;
  logic [WIDTH-1:0] rd_mux;

  always_comb begin
    sw_sel = '0;
    hw_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Address == ADDR_WIDTH'(i)) begin
        sw_sel[i] = 1'b1;
        rd_mux    = regs[i];
      end
      if (HwAddress == ADDR_WIDTH'(i)) begin
        hw_sel[i] = 1'b1;
      end
    end
  end

  logic             in_range;
  logic             sw_ro;
  logic             wr_ok;
  logic             rd_do;
  logic [DEPTH-1:0] sw_we;
  logic [DEPTH-1:0] hw_we;

  assign in_range = |sw_sel;
  assign sw_ro    = |(sw_sel & RO_MASK);
  assign wr_ok    = WrEn & in_range & ~sw_ro;
  assign rd_do    = RdEn & ~WrEn;
  // Software reaches only RW entries, hardware only RO entries, so the two
  // write enables never select the same register.
  assign sw_we    = sw_sel & ~RO_MASK & {DEPTH{wr_ok}};
  assign hw_we    = hw_sel &  RO_MASK & {DEPTH{HwWrEn}};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Err          <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sw_we[i]) begin
          regs[i] <= WrData;
        end else if (hw_we[i]) begin
          regs[i] <= HwWrData;
        end
      end
      // rd_mux samples the pre-edge contents, so a same-cycle hardware write
      // is only visible to the following read.
      if (rd_do) begin
        RdData <= rd_mux;
      end
      RdData_Valid <= rd_do;
      Err          <= (WrEn & ~wr_ok) | (rd_do & ~in_range);
    end
  end

  for (genvar k = 0; k < NUM_EXPORT; k++) begin : g_export
    assign REG_OUT[slice_lo(k, WIDTH) +: WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_reg_file_cfg.sv
// Directed testbench for reg_file_cfg with DEPTH=12, RO registers 6 and 7,
// four exported registers.
module tb_reg_file_cfg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NEXP  = 4;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] WrData;
  logic [AW-1:0]    Address;
  logic             WrEn;
  logic             RdEn;
  logic             HwWrEn;
  logic [AW-1:0]    HwAddress;
  logic [WIDTH-1:0] HwWrData;
  logic [WIDTH-1:0] RdData;
  logic             RdData_Valid;
  logic             Err;
  logic [NEXP*WIDTH-1:0] REG_OUT;

  int errors = 0;
  int checks = 0;

  reg_file_cfg #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .RO_MASK   (12'h0C0),
    .NUM_EXPORT(NEXP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WrData      (WrData),
    .Address     (Address),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .HwWrEn      (HwWrEn),
    .HwAddress   (HwAddress),
    .HwWrData    (HwWrData),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .Err         (Err),
    .REG_OUT     (REG_OUT)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WrEn = 1'b0; RdEn = 1'b0; HwWrEn = 1'b0;
    WrData = '0; Address = '0; HwAddress = '0; HwWrData = '0;
  endtask

  task automatic sw_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    idle();
    WrEn = 1'b1; Address = a; WrData = d;
  endtask

  task automatic sw_read(input logic [AW-1:0] a);
    idle();
    RdEn = 1'b1; Address = a;
  endtask

  // Scenarios
  task automatic test_reset();
    RST = 1'b0;
    sw_write(4'd2, 8'h99);
    RdEn = 1'b1;
    tick();
    checks++;
    if (RdData !== 8'h00 || RdData_Valid !== 1'b0 || Err !== 1'b0 || REG_OUT !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: RdData=%h V=%b Err=%b REG_OUT=%h, want 00 0 0 00000000",
               RdData, RdData_Valid, Err, REG_OUT);
    end
    idle();
    @(negedge CLK);
    RST = 1'b1;
    tick();
    checks++;
    if (REG_OUT !== 32'h0 || RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: REG_OUT=%h V=%b Err=%b, want 00000000 0 0",
               REG_OUT, RdData_Valid, Err);
    end
  endtask

  task automatic test_write_read();
    sw_write(4'd2, 8'hA5);
    tick();
    checks++;
    if (REG_OUT[23:16] !== 8'hA5 || RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL wr2: REG_OUT[23:16]=%h V=%b Err=%b, want a5 0 0",
               REG_OUT[23:16], RdData_Valid, Err);
    end
    sw_read(4'd2);
    tick();
    checks++;
    if (RdData !== 8'hA5 || RdData_Valid !== 1'b1 || Err !== 1'b0) begin
      errors++;
      $display("FAIL rd2: RdData=%h V=%b Err=%b, want a5 1 0", RdData, RdData_Valid, Err);
    end
    idle();
    tick();
    checks++;
    if (RdData !== 8'hA5 || RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: RdData=%h V=%b Err=%b, want a5 0 0", RdData, RdData_Valid, Err);
    end
  endtask

  task automatic test_read_only();
    sw_write(4'd6, 8'h33);
    tick();
    checks++;
    if (Err !== 1'b1 || RdData_Valid !== 1'b0) begin
      errors++;
      $display("FAIL ro_wr_err: Err=%b V=%b, want 1 0", Err, RdData_Valid);
    end
    idle();
    tick();
    checks++;
    if (Err !== 1'b0) begin
      errors++;
      $display("FAIL ro_err_pulse: Err=%b, want 0", Err);
    end
    sw_read(4'd6);
    HwWrEn = 1'b1; HwAddress = 4'd6; HwWrData = 8'h5A;
    tick();
    checks++;
    if (RdData !== 8'h00 || RdData_Valid !== 1'b1 || Err !== 1'b0) begin
      errors++;
      $display("FAIL hw_rd_same: RdData=%h V=%b Err=%b, want 00 1 0", RdData, RdData_Valid, Err);
    end
    sw_read(4'd6);
    tick();
    checks++;
    if (RdData !== 8'h5A || RdData_Valid !== 1'b1) begin
      errors++;
      $display("FAIL hw_rd_next: RdData=%h V=%b, want 5a 1", RdData, RdData_Valid);
    end
  endtask

  task automatic test_out_of_range();
    sw_read(4'd13);
    tick();
    checks++;
    if (RdData !== 8'h00 || RdData_Valid !== 1'b1 || Err !== 1'b1) begin
      errors++;
      $display("FAIL rd13: RdData=%h V=%b Err=%b, want 00 1 1", RdData, RdData_Valid, Err);
    end
    sw_write(4'd12, 8'hFF);
    tick();
    checks++;
    if (Err !== 1'b1 || RdData_Valid !== 1'b0 || REG_OUT !== 32'h00A5_0000) begin
      errors++;
      $display("FAIL wr12: Err=%b V=%b REG_OUT=%h, want 1 0 00a50000", Err, RdData_Valid, REG_OUT);
    end
    idle();
    tick();
    checks++;
    if (Err !== 1'b0 || RdData_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rng_quiet: Err=%b V=%b, want 0 0", Err, RdData_Valid);
    end
  endtask

  task automatic test_hw_to_rw();
    idle();
    HwWrEn = 1'b1; HwAddress = 4'd3; HwWrData = 8'h11;
    tick();
    checks++;
    if (REG_OUT[31:24] !== 8'h00 || Err !== 1'b0) begin
      errors++;
      $display("FAIL hw_rw3: REG_OUT[31:24]=%h Err=%b, want 00 0", REG_OUT[31:24], Err);
    end
  endtask

  task automatic test_hw_sw_same_cycle();
    sw_write(4'd0, 8'h42);
    HwWrEn = 1'b1; HwAddress = 4'd7; HwWrData = 8'h9C;
    tick();
    checks++;
    if (REG_OUT[7:0] !== 8'h42 || Err !== 1'b0) begin
      errors++;
      $display("FAIL dual_wr_sw: REG_OUT[7:0]=%h Err=%b, want 42 0", REG_OUT[7:0], Err);
    end
    sw_read(4'd7);
    tick();
    checks++;
    if (RdData !== 8'h9C || RdData_Valid !== 1'b1) begin
      errors++;
      $display("FAIL dual_wr_hw: RdData=%h V=%b, want 9c 1", RdData, RdData_Valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_d;
    sw_write(4'd1, 8'h3C);
    RdEn = 1'b1;
    tick();
    checks++;
    if (REG_OUT[15:8] !== 8'h3C || RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_both: REG_OUT[15:8]=%h V=%b Err=%b, want 3c 0 0",
               REG_OUT[15:8], RdData_Valid, Err);
    end
    exp_q = '{8'h42, 8'h3C, 8'hA5, 8'h00};
    for (int a = 0; a < 4; a++) begin
      sw_read(AW'(a));
      tick();
      exp_d = exp_q.pop_front();
      checks++;
      if (RdData !== exp_d || RdData_Valid !== 1'b1 || Err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rd%0d: RdData=%h V=%b Err=%b, want %h 1 0",
                 a, RdData, RdData_Valid, Err, exp_d);
      end
    end
    idle();
    tick();
    checks++;
    if (RdData_Valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: V=%b, want 0", RdData_Valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < DEPTH; a++) begin
      if (a != 6 && a != 7) begin
        sw_write(AW'(a), 8'h77);
        tick();
      end
    end
    sw_read(4'd5);
    tick();
    checks++;
    if (REG_OUT !== 32'h7777_7777 || RdData !== 8'h77 || RdData_Valid !== 1'b1) begin
      errors++;
      $display("FAIL fill: REG_OUT=%h RdData=%h V=%b, want 77777777 77 1",
               REG_OUT, RdData, RdData_Valid);
    end
    idle();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (REG_OUT !== 32'h0 || RdData !== 8'h00 || RdData_Valid !== 1'b0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: REG_OUT=%h RdData=%h V=%b Err=%b, want 00000000 00 0 0",
               REG_OUT, RdData, RdData_Valid, Err);
    end
    #1;
    RST = 1'b1;
    sw_read(4'd5);
    tick();
    checks++;
    if (RdData !== 8'h00 || RdData_Valid !== 1'b1 || Err !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_rst: RdData=%h V=%b Err=%b, want 00 1 0", RdData, RdData_Valid, Err);
    end
    sw_read(4'd9);
    tick();
    checks++;
    if (RdData !== 8'h00 || RdData_Valid !== 1'b1) begin
      errors++;
      $display("FAIL rd9_after_rst: RdData=%h V=%b, want 00 1", RdData, RdData_Valid);
    end
  endtask

  initial begin
    RST = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_read_only();
    test_out_of_range();
    test_hw_to_rw();
    test_hw_sw_same_cycle();
    test_back_to_back();
    test_reset_mid();
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_cfg.md
REG_FILE_CFG -- requirements
Module: reg_file_cfg

Interface
REQ-001 Parameter WIDTH, default 8: data width of every register, in bits.
REQ-002 Parameter DEPTH, default 16: number of registers; legal range 2..2^ADDR_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 4: width of Address and HwAddress.
REQ-004 Parameter RO_MASK, default {DEPTH{1'b0}}: bit i = 1 makes register i software-read-only and hardware-writable.
REQ-005 Parameter NUM_EXPORT, default 4: number of low registers driven continuously on REG_OUT; legal range 1..DEPTH.
REQ-006 CLK  input  1  single block clock; all state updates on its rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-low.
REQ-008 WrData  input  WIDTH  software write data.
REQ-009 Address  input  ADDR_WIDTH  software read/write address.
REQ-010 WrEn  input  1  software write strobe, sampled each cycle.
REQ-011 RdEn  input  1  software read strobe, sampled each cycle.
REQ-012 HwWrEn  input  1  hardware (status) write strobe.
REQ-013 HwAddress  input  ADDR_WIDTH  hardware write address.
REQ-014 HwWrData  input  WIDTH  hardware write data.
REQ-015 RdData  output  WIDTH  registered read data.
REQ-016 RdData_Valid  output  1  one-cycle pulse marking RdData as a fresh read response.
REQ-017 Err  output  1  one-cycle pulse flagging a rejected software access.
REQ-018 REG_OUT  output  NUM_EXPORT*WIDTH  registers 0..NUM_EXPORT-1, with register k on bits [k*WIDTH +: WIDTH].

Function
REQ-019 An address is in range when it is less than DEPTH.
REQ-020 WrEn=1 with an in-range address and RO_MASK[Address]=0 SHALL write WrData at the edge; RdData_Valid=0 and Err=0 next cycle.
REQ-021 WrEn=1 to a read-only or out-of-range address SHALL leave all registers unchanged and pulse Err for one cycle.
REQ-022 WrEn=1 with RdEn=1 SHALL perform the write only; the read is dropped and RdData_Valid=0.
REQ-023 RdEn=1 with WrEn=0 to an in-range address SHALL load RdData with the pre-edge register value and pulse RdData_Valid; latency is 1 cycle.
REQ-024 RdEn=1 to an out-of-range address SHALL load RdData=0, pulse RdData_Valid and pulse Err in the same cycle.
REQ-025 With WrEn=0 and RdEn=0, RdData SHALL hold its value and RdData_Valid=0, Err=0.
REQ-026 Back-to-back reads SHALL each produce one RdData_Valid pulse, so RdData_Valid stays high continuously for consecutive RdEn cycles.
REQ-027 HwWrEn=1 SHALL write HwWrData only when HwAddress is in range and RO_MASK[HwAddress]=1; otherwise it is ignored silently, with no Err.
REQ-028 A hardware write and a software write in the same cycle SHALL both take effect; they cannot conflict because their target sets are disjoint.
REQ-029 A hardware write and a software read of the same address in the same cycle SHALL return the old value; the new value is returned from the next cycle on.
REQ-030 REG_OUT SHALL reflect a write one cycle after the write strobe.
REQ-031 Err and RdData_Valid SHALL never be high without a corresponding strobe in the previous cycle.

Reset
REQ-032 RST low SHALL immediately clear all registers, RdData, RdData_Valid and Err to 0, regardless of CLK.
REQ-033 A write or read strobe coincident with RST low SHALL have no effect.
REQ-034 The first strobe after RST deasserts SHALL be processed normally.

Structure
REQ-035 Default parameter values and the REG_OUT slice-index helper SHALL be constants in shared package reg_file_pkg.
REQ-036 The block SHALL be flat, with no sub-modules; address-range and RO decode are local combinational logic.
REQ-037 Storage SHALL be one register array, with a generate loop for REG_OUT.

Verification (bench: DEPTH=12, ADDR_WIDTH=4, RO_MASK=12'h0C0, NUM_EXPORT=4)
REQ-038 Write 0xA5 to address 2, then read address 2 -> REG_OUT[23:16]=0xA5 after 1 cycle; RdData=0xA5 with one RdData_Valid pulse; Err=0.
REQ-039 SW write 0x33 to address 6 -> register 6 stays 0 and Err pulses; then HwWrEn 0x5A to address 6 with a simultaneous read of address 6 -> RdData=0x00; a read the next cycle -> RdData=0x5A.
REQ-040 Read address 13 -> RdData=0x00, RdData_Valid=1 and Err=1 in the same cycle; write 0xFF to address 12 -> Err pulses and no register changes.
REQ-041 WrEn and RdEn both high at address 1 with 0x3C -> register 1=0x3C and RdData_Valid=0; next, 4 consecutive reads of addresses 0..3 -> RdData_Valid high for 4 cycles with the matching data.
REQ-042 Fill all RW registers with 0x77, then pulse RST low mid-cycle -> all outputs and REG_OUT are 0 before the next CLK edge; the first read after release -> 0x00.
REQ-043 HwWrEn to RW address 3 with 0x11 -> register 3 unchanged and Err=0.
